// File: rtl/knight_move_seq_pkg.sv
// Shared constants and types for the knight tour move sequencer:
// headings, opcodes, one-hot move codes, FSM state and latched leg record.
package kt_pkg;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [3:0] OPC_MOVE    = 4'h4;
  localparam logic [3:0] OPC_FANFARE = 4'h5;

  localparam logic [7:0] RESP_LEG  = 8'h5A;
  localparam logic [7:0] RESP_DONE = 8'hA5;

  // One-hot move codes, named by (dx, dy) with +y pointing north
  localparam logic [7:0] MV_P1_P2 = 8'h01;
  localparam logic [7:0] MV_M1_P2 = 8'h02;
  localparam logic [7:0] MV_M2_P1 = 8'h04;
  localparam logic [7:0] MV_M2_M1 = 8'h08;
  localparam logic [7:0] MV_M1_M2 = 8'h10;
  localparam logic [7:0] MV_P1_M2 = 8'h20;
  localparam logic [7:0] MV_P2_M1 = 8'h40;
  localparam logic [7:0] MV_P2_P1 = 8'h80;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    XLEG  = 3'd2,
    XWAIT = 3'd3,
    YLEG  = 3'd4,
    YWAIT = 3'd5
  } state_t;

  typedef struct packed {
    logic [7:0] x_hdg;
    logic [3:0] x_sq;
    logic [7:0] y_hdg;
    logic [3:0] y_sq;
  } leg_t;

endpackage

// File: rtl/knight_move_seq_decode.sv
// Combinational decode of a one-hot knight move into an x leg and a y leg;
// anything that is not exactly one bit set is flagged illegal.
module knight_move_decode
  import kt_pkg::*;
(
  input  logic [7:0] mv,
  output leg_t       leg,
  output logic       illegal
);

  always_comb begin
    leg     = '0;
    illegal = 1'b0;
    case (mv)
      MV_P1_P2: leg = '{x_hdg: HDG_E, x_sq: 4'h1, y_hdg: HDG_N, y_sq: 4'h2};
      MV_M1_P2: leg = '{x_hdg: HDG_W, x_sq: 4'h1, y_hdg: HDG_N, y_sq: 4'h2};
      MV_M2_P1: leg = '{x_hdg: HDG_W, x_sq: 4'h2, y_hdg: HDG_N, y_sq: 4'h1};
      MV_M2_M1: leg = '{x_hdg: HDG_W, x_sq: 4'h2, y_hdg: HDG_S, y_sq: 4'h1};
      MV_M1_M2: leg = '{x_hdg: HDG_W, x_sq: 4'h1, y_hdg: HDG_S, y_sq: 4'h2};
      MV_P1_M2: leg = '{x_hdg: HDG_E, x_sq: 4'h1, y_hdg: HDG_S, y_sq: 4'h2};
      MV_P2_M1: leg = '{x_hdg: HDG_E, x_sq: 4'h2, y_hdg: HDG_S, y_sq: 4'h1};
      MV_P2_P1: leg = '{x_hdg: HDG_E, x_sq: 4'h2, y_hdg: HDG_N, y_sq: 4'h1};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/knight_move_seq.sv
// Knight tour sequencer: splits each solver move into an x leg and a y leg
// command, and passes UART commands straight through while idle.
// Optional KNIGHT_MOVE_SEQ_FANFARE_EN: vertical legs use the fanfare opcode.
module knight_move_seq
  import kt_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  mv,
  input  logic        mv_vld,
  output logic        mv_rdy,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        clr_cmd_rdy_UART,
  output logic [7:0]  resp,
  output logic        tour_busy,
  output logic        tour_err
);

`ifdef KNIGHT_MOVE_SEQ_FANFARE_EN
  localparam logic [3:0] VERT_OPC = OPC_FANFARE;
`else
  localparam logic [3:0] VERT_OPC = OPC_MOVE;
`endif

  localparam logic [4:0] LAST_MOVE = 5'(NUM_MOVES - 1);

  state_t     state;
  logic [4:0] cnt;
  logic       err_q;
  leg_t       leg_q;
  leg_t       leg_d;
  logic       mv_illegal;

  knight_move_decode u_dec (
    .mv      (mv),
    .leg     (leg_d),
    .illegal (mv_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
      leg_q <= '0;
    end else begin
      case (state)
        IDLE: if (start_tour) begin
          state <= FETCH;
          cnt   <= '0;
          err_q <= 1'b0;
        end
        FETCH: if (mv_vld) begin
          if (mv_illegal) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            leg_q <= leg_d;
            state <= XLEG;
          end
        end
        XLEG:  if (clr_cmd_rdy) state <= XWAIT;
        XWAIT: if (send_resp)   state <= YLEG;
        YLEG:  if (clr_cmd_rdy) state <= YWAIT;
        YWAIT: if (send_resp) begin
          // Termination compares the count of moves already completed
          state <= (cnt == LAST_MOVE) ? IDLE : FETCH;
          if (cnt != 5'h1F) cnt <= cnt + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; IDLE is a pure UART pass-through
  always_comb begin
    cmd              = '0;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_LEG;
    mv_rdy           = 1'b0;
    tour_busy        = 1'b1;
    case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        tour_busy        = 1'b0;
      end
      FETCH: mv_rdy = 1'b1;
      XLEG: begin
        cmd     = {OPC_MOVE, leg_q.x_hdg, leg_q.x_sq};
        cmd_rdy = 1'b1;
      end
      XWAIT: cmd = {OPC_MOVE, leg_q.x_hdg, leg_q.x_sq};
      YLEG: begin
        cmd     = {VERT_OPC, leg_q.y_hdg, leg_q.y_sq};
        cmd_rdy = 1'b1;
      end
      YWAIT: begin
        cmd  = {VERT_OPC, leg_q.y_hdg, leg_q.y_sq};
        resp = (cnt == LAST_MOVE) ? RESP_DONE : RESP_LEG;
      end
      default: ;
    endcase
  end

  assign tour_err = err_q;

endmodule

// File: tb/tb_knight_move_seq.sv
// Self-checking bench for knight_move_seq (NUM_MOVES=2): table of moves with
// a scoreboard of expected leg commands, plus hand-written corner sequences.
module tb_knight_move_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  mv;
  logic        mv_vld;
  logic        mv_rdy;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy_UART;
  logic [7:0]  resp;
  logic        tour_busy;
  logic        tour_err;

`ifdef KNIGHT_MOVE_SEQ_FANFARE_EN
  localparam logic [3:0] VOP = 4'h5;
`else
  localparam logic [3:0] VOP = 4'h4;
`endif

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] xcmd;
    logic [11:0] ylow;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;

  always #5 clk = ~clk;

  knight_move_seq #(.NUM_MOVES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_tour       (start_tour),
    .mv               (mv),
    .mv_vld           (mv_vld),
    .mv_rdy           (mv_rdy),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .resp             (resp),
    .tour_busy        (tour_busy),
    .tour_err         (tour_err)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hi(input bit use_cmd, input string nm);
    int k = 0;
    while (!(use_cmd ? cmd_rdy : mv_rdy) && k < 50) begin
      step();
      k++;
    end
    chk(nm, use_cmd ? cmd_rdy : mv_rdy, 1);
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
  endtask

  task automatic do_move(input vec_t v);
    wait_hi(1'b0, "wait_mv_rdy");
    mv     = v.mv;
    mv_vld = 1'b1;
    exp_q.push_back(v.xcmd);
    exp_q.push_back({VOP, v.ylow});
    step();
    mv_vld = 1'b0;
    mv     = 8'h00;
  endtask

  task automatic do_leg(input bit xleg);
    logic [15:0] e;
    wait_hi(1'b1, "wait_cmd_rdy");
    if (exp_q.size() == 0) chk("sb_empty", 16'd1, 16'd0);
    else begin
      e = exp_q.pop_front();
      chk(xleg ? "x_cmd" : "y_cmd", cmd, e);
    end
    chk("busy_in_leg", tour_busy, 1);
    clr_cmd_rdy = 1'b1;
    #1;
    if (cmd_rdy && clr_cmd_rdy) hs_cnt++;
    step();
    clr_cmd_rdy = 1'b0;
    #1;
    chk("rdy_drop", cmd_rdy, 0);
    if (xleg) chk("xwait_resp", resp, 16'h5A);
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h01, 16'h4BF1, 12'h002};
    vecs[1] = '{8'h02, 16'h43F1, 12'h002};
    vecs[2] = '{8'h04, 16'h43F2, 12'h001};
    vecs[3] = '{8'h08, 16'h43F2, 12'h7F1};
    vecs[4] = '{8'h10, 16'h43F1, 12'h7F2};
    vecs[5] = '{8'h20, 16'h4BF1, 12'h7F2};
    vecs[6] = '{8'h40, 16'h4BF2, 12'h7F1};
    vecs[7] = '{8'h80, 16'h4BF2, 12'h001};

    rst = 1'b1; start_tour = 1'b0; mv = 8'h00; mv_vld = 1'b0;
    cmd_UART = 16'h0; cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    repeat (2) step();
    chk("rst_busy", tour_busy, 0);
    chk("rst_err", tour_err, 0);
    chk("rst_mv_rdy", mv_rdy, 0);
    chk("rst_resp", resp, 16'hA5);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    rst = 1'b0;
    step();

    // UART pass-through in IDLE
    cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1;
    #1;
    chk("uart_cmd", cmd, 16'h2000);
    chk("uart_cmd_rdy", cmd_rdy, 1);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("uart_clr", clr_cmd_rdy_UART, 1);
    step();
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    #1;
    chk("uart_clr_drop", clr_cmd_rdy_UART, 0);

    // Four two-move tours over the move table
    for (int t = 0; t < 4; t++) begin
      hs_cnt = 0;
      pulse_start();
      chk("start_busy", tour_busy, 1);
      if (t == 0) begin
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        chk("fetch_ignores_resp", mv_rdy, 1);
      end
      for (int m = 0; m < 2; m++) begin
        do_move(vecs[2*t + m]);
        if (t == 1 && m == 0) begin
          pulse_start();
          chk("start_while_busy", cmd_rdy, 1);
          chk("start_while_busy_cmd", cmd, exp_q[0]);
        end
        do_leg(1'b1);
        do_leg(1'b0);
        if (m == 0) chk("mid_tour_busy", tour_busy, 1);
      end
      chk("tour_handshakes", 16'(hs_cnt), 16'd4);
      chk("tour_end_busy", tour_busy, 0);
      chk("tour_end_resp", resp, 16'hA5);
      chk("tour_end_err", tour_err, 0);
    end

    // Illegal moves: two bits set, then no bits set
    pulse_start();
    wait_hi(1'b0, "ill_wait_mv_rdy");
    mv = 8'h03; mv_vld = 1'b1;
    step();
    mv_vld = 1'b0; mv = 8'h00;
    chk("ill03_err", tour_err, 1);
    chk("ill03_busy", tour_busy, 0);
    chk("ill03_mv_rdy", mv_rdy, 0);
    step();
    chk("ill03_no_cmd", cmd_rdy, 0);
    pulse_start();
    chk("restart_clears_err", tour_err, 0);
    mv = 8'h00; mv_vld = 1'b1;
    step();
    mv_vld = 1'b0;
    chk("ill00_err", tour_err, 1);
    chk("ill00_busy", tour_busy, 0);
    step();
    chk("ill00_no_cmd", cmd_rdy, 0);

    // UART command held off during a tour, then reset mid-XWAIT
    exp_q.delete();
    pulse_start();
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    #1;
    chk("tour_hides_uart_rdy", cmd_rdy, 0);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("tour_blocks_uart_clr", clr_cmd_rdy_UART, 0);
    clr_cmd_rdy = 1'b0;
    do_move(vecs[5]);
    wait_hi(1'b1, "rst_wait_cmd_rdy");
    chk("rst_seq_xcmd", cmd, 16'h4BF1);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    #1;
    chk("rst_seq_in_xwait", resp, 16'h5A);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", tour_busy, 0);
    chk("async_rst_cmd", cmd, 16'h1234);
    chk("async_rst_cmd_rdy", cmd_rdy, 1);
    chk("async_rst_resp", resp, 16'hA5);
    chk("async_rst_mv_rdy", mv_rdy, 0);
    exp_q.delete();
    step();
    rst = 1'b0;
    cmd_rdy_UART = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
